// File: rtl/ssd1306_spi_receiver.sv
// ssd1306_spi_receiver: oversampling SSD1306 4-wire SPI responder that decodes window/display
// commands and turns GDDRAM data bytes into addressed write strobes.
module ssd1306_spi_receiver #(
    parameter int COLS  = 128,
    parameter int PAGES = 8
) (
    input  logic                                   clk_in,
    input  logic                                   resetn_in,
    input  logic                                   spi_csn_in,
    input  logic                                   spi_dc_in,
    input  logic                                   spi_clk_in,
    input  logic                                   spi_mosi_in,
    output logic [7:0]                             byte_out,
    output logic                                   byte_dc_out,
    output logic                                   byte_valid_out,
    output logic                                   gram_we_out,
    output logic [$clog2(PAGES)+$clog2(COLS)-1:0]  gram_addr_out,
    output logic [7:0]                             gram_data_out,
    output logic                                   display_on_out,
    output logic                                   frame_done_out,
    output logic                                   cmd_error_out
);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;

    state_t          state, state_nx;
    logic [1:0]      csn_s, dc_s, sck_s, mosi_s;
    logic            sck_d;
    logic [2:0]      bit_cnt;
    logic [6:0]      shift;
    logic            page_cmd, one_arg;
    logic [CW-1:0]   arg_start;
    logic [CW-1:0]   col_start, col_end, col_ptr;
    logic [PW-1:0]   page_start, page_end, page_ptr;

    logic csn_hi, sck_rise, cmd_valid, data_valid, is_win, is_one, abort, col_wrap, page_wrap;

    assign csn_hi     = csn_s[1];
    assign sck_rise   = sck_s[1] & ~sck_d & ~csn_hi;
    assign cmd_valid  = byte_valid_out & ~byte_dc_out;
    assign data_valid = byte_valid_out & byte_dc_out;
    assign is_win     = byte_out == 8'h21 || byte_out == 8'h22;
    assign is_one     = byte_out inside {8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};
    // A pending argument is lost if data arrives or the frame ends first.
    assign abort      = state != IDLE && (data_valid || (!byte_valid_out && csn_hi));
    assign col_wrap   = col_ptr == col_end;
    assign page_wrap  = page_ptr == page_end;

    always_comb begin
        state_nx = state;
        if (abort)
            state_nx = IDLE;
        else if (cmd_valid)
            state_nx = state == IDLE ? (is_win || is_one ? ARG1 : IDLE)
                     : state == ARG1 ? (one_arg ? IDLE : ARG2) : IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            csn_s  <= 2'b11;
            dc_s   <= '0;
            sck_s  <= '0;
            mosi_s <= '0;
            sck_d  <= 1'b0;
        end else begin
            csn_s  <= {csn_s[0], spi_csn_in};
            dc_s   <= {dc_s[0], spi_dc_in};
            sck_s  <= {sck_s[0], spi_clk_in};
            mosi_s <= {mosi_s[0], spi_mosi_in};
            sck_d  <= sck_s[1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shift          <= '0;
            byte_out       <= '0;
            byte_dc_out    <= 1'b0;
            byte_valid_out <= 1'b0;
            gram_we_out    <= 1'b0;
            gram_addr_out  <= '0;
            gram_data_out  <= '0;
            display_on_out <= 1'b0;
            frame_done_out <= 1'b0;
            cmd_error_out  <= 1'b0;
            page_cmd       <= 1'b0;
            one_arg        <= 1'b0;
            arg_start      <= '0;
            col_start      <= '0;
            col_end        <= CW'(COLS - 1);
            col_ptr        <= '0;
            page_start     <= '0;
            page_end       <= PW'(PAGES - 1);
            page_ptr       <= '0;
        end else begin
            state          <= state_nx;
            byte_valid_out <= 1'b0;
            gram_we_out    <= 1'b0;
            frame_done_out <= 1'b0;
            if (csn_hi) begin
                bit_cnt <= '0;
                shift   <= '0;
                if (bit_cnt != 3'd0)
                    cmd_error_out <= 1'b1;
            end else if (sck_rise) begin
                shift   <= {shift[5:0], mosi_s[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_out       <= {shift, mosi_s[1]};
                    byte_dc_out    <= dc_s[1];
                    byte_valid_out <= 1'b1;
                end
            end
            if (abort)
                cmd_error_out <= 1'b1;
            if (cmd_valid && state == IDLE) begin
                page_cmd <= byte_out == 8'h22;
                one_arg  <= is_one;
                if (byte_out[7:1] == 7'h57)
                    display_on_out <= byte_out[0];
            end
            if (cmd_valid && state == ARG1)
                arg_start <= byte_out[CW-1:0];
            if (cmd_valid && state == ARG2) begin
                if (page_cmd) begin
                    page_start <= arg_start[PW-1:0];
                    page_end   <= byte_out[PW-1:0];
                    page_ptr   <= arg_start[PW-1:0];
                end else begin
                    col_start <= arg_start;
                    col_end   <= byte_out[CW-1:0];
                    col_ptr   <= arg_start;
                end
            end
            if (data_valid) begin
                gram_we_out    <= 1'b1;
                gram_addr_out  <= {page_ptr, col_ptr};
                gram_data_out  <= byte_out;
                frame_done_out <= col_wrap && page_wrap;
                col_ptr        <= col_wrap ? col_start : col_ptr + 1'b1;
                if (col_wrap)
                    page_ptr <= page_wrap ? page_start : page_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// tb_ssd1306_spi_receiver: directed plus randomized SPI traffic checked against a
// byte-level model of the SSD1306 command/data semantics.
module tb_ssd1306_spi_receiver;
    logic       clk = 0, resetn = 0;
    logic       csn = 1, dc = 0, sck = 0, mosi = 0;
    logic [7:0] byte_out, gram_data_out;
    logic [9:0] gram_addr_out;
    logic       byte_dc_out, byte_valid_out, gram_we_out, display_on_out, frame_done_out, cmd_error_out;

    ssd1306_spi_receiver dut (
        .clk_in(clk), .resetn_in(resetn),
        .spi_csn_in(csn), .spi_dc_in(dc), .spi_clk_in(sck), .spi_mosi_in(mosi),
        .byte_out(byte_out), .byte_dc_out(byte_dc_out), .byte_valid_out(byte_valid_out),
        .gram_we_out(gram_we_out), .gram_addr_out(gram_addr_out), .gram_data_out(gram_data_out),
        .display_on_out(display_on_out), .frame_done_out(frame_done_out), .cmd_error_out(cmd_error_out)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int hp = 4;

    // Behavioural model state: windows, pointers, pending argument count
    int m_cs, m_ce, m_ps, m_pe, m_col, m_page, m_pend, m_tmp;
    bit m_one, m_pcmd, m_disp, m_err;
    logic [8:0]  exp_bytes[$];
    logic [18:0] exp_wr[$];
    int          seen_addr[$];
    int          frames, frame_at, last_data, byte_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic mdl_reset();
        m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_col = 0; m_page = 0;
        m_pend = 0; m_disp = 0; m_err = 0; m_one = 0; m_pcmd = 0;
    endtask

    task automatic mdl_byte(input logic [7:0] b, input logic d);
        int addr;
        bit fd;
        exp_bytes.push_back({d, b});
        if (d) begin
            addr = m_page * 128 + m_col;
            fd = 0;
            if (m_col == m_ce) begin
                m_col = m_cs;
                fd = m_page == m_pe;
                m_page = fd ? m_ps : (m_page + 1) % 8;
            end else
                m_col = (m_col + 1) % 128;
            exp_wr.push_back({fd, addr[9:0], b});
            if (m_pend != 0) begin m_err = 1; m_pend = 0; end
        end else if (m_pend == 1) begin
            if (m_one) m_pend = 0;
            else begin m_tmp = b; m_pend = 2; end
        end else if (m_pend == 2) begin
            if (m_pcmd) begin m_ps = m_tmp % 8; m_pe = b % 8; m_page = m_ps; end
            else begin m_cs = m_tmp % 128; m_ce = b % 128; m_col = m_cs; end
            m_pend = 0;
        end else if (b == 8'h21 || b == 8'h22) begin
            m_pend = 1; m_one = 0; m_pcmd = b == 8'h22;
        end else if (b inside {8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB}) begin
            m_pend = 1; m_one = 1;
        end else if (b == 8'hAF) m_disp = 1;
        else if (b == 8'hAE) m_disp = 0;
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (byte_valid_out) begin
                byte_cnt++;
                if (exp_bytes.size() == 0) chk("spurious_byte_valid", byte_valid_out, 0);
                else chk("byte", {byte_dc_out, byte_out}, exp_bytes.pop_front());
            end
            if (gram_we_out) begin
                seen_addr.push_back(int'(gram_addr_out));
                last_data = gram_data_out;
                if (frame_done_out) begin frames++; frame_at = seen_addr.size(); end
                if (exp_wr.size() == 0) chk("spurious_gram_we", gram_we_out, 0);
                else begin
                    logic [18:0] e;
                    e = exp_wr.pop_front();
                    chk("gram_addr", gram_addr_out, e[17:8]);
                    chk("gram_data", gram_data_out, e[7:0]);
                    chk("frame_done", frame_done_out, e[18]);
                end
            end else if (frame_done_out)
                chk("frame_done_without_we", frame_done_out, 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic d);
        mdl_byte(b, d);
        dc = d;
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            repeat (hp) @(negedge clk);
            sck = 1;
            repeat (hp) @(negedge clk);
            sck = 0;
        end
        repeat (4) @(negedge clk);
        chk("display_on", display_on_out, m_disp);
        chk("cmd_error", cmd_error_out, m_err);
    endtask

    task automatic cs_toggle();
        csn = 1;
        repeat (6) @(negedge clk);
        if (m_pend != 0) begin m_err = 1; m_pend = 0; end
        chk("cmd_error_cs", cmd_error_out, m_err);
        csn = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic abort_bits(input int k);
        dc = 1'($urandom);
        for (int i = 0; i < k; i++) begin
            mosi = 1'($urandom);
            repeat (hp) @(negedge clk);
            sck = 1;
            repeat (hp) @(negedge clk);
            sck = 0;
        end
        csn = 1;
        repeat (6) @(negedge clk);
        m_err = 1; m_pend = 0;
        chk("cmd_error_abort", cmd_error_out, 1);
        csn = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk) resetn = 0;
        @(negedge clk) resetn = 1;
        chk("rst_queue_empty", exp_bytes.size() + exp_wr.size(), 0);
        exp_bytes.delete();
        exp_wr.delete();
        mdl_reset();
        chk("rst_byte", {byte_valid_out, byte_dc_out, byte_out}, 0);
        chk("rst_gram", {gram_we_out, gram_addr_out, gram_data_out}, 0);
        chk("rst_flags", {display_on_out, frame_done_out, cmd_error_out}, 0);
    endtask

    task automatic send_win(input logic [7:0] op, input logic [7:0] s, input logic [7:0] e);
        send_byte(op, 0);
        send_byte(s, 0);
        send_byte(e, 0);
    endtask

    logic [7:0] one_tab [9] = '{8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};
    int t2_exp [4] = '{'h37E, 'h37F, 'h3FE, 'h3FF};

    initial begin
        int bad;
        mdl_reset();
        repeat (4) @(negedge clk);
        resetn = 1;
        @(negedge clk);
        chk("init_byte", {byte_valid_out, byte_dc_out, byte_out}, 0);
        chk("init_gram", {gram_we_out, gram_addr_out, gram_data_out}, 0);
        chk("init_flags", {display_on_out, frame_done_out, cmd_error_out}, 0);
        csn = 0;
        repeat (3) @(negedge clk);

        send_win(8'h21, 8'h00, 8'h7F);
        send_win(8'h22, 8'h00, 8'h07);
        send_byte(8'hA5, 1);
        chk("t1_we_count", seen_addr.size(), 1);
        chk("t1_addr", seen_addr[0], 0);
        chk("t1_data", last_data, 8'hA5);
        chk("t1_dc", byte_dc_out, 1);
        chk("t1_err", cmd_error_out, 0);

        send_win(8'h21, 8'd126, 8'd127);
        send_win(8'h22, 8'd6, 8'd7);
        seen_addr.delete(); frames = 0; frame_at = 0;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
        for (int i = 0; i < 4; i++) chk("t2_addr", seen_addr[i], t2_exp[i]);
        chk("t2_frames", frames, 1);
        chk("t2_frame_at", frame_at, 4);
        chk("t2_fifth", seen_addr[4], 'h37E);

        send_byte(8'hAF, 0);
        chk("t4_on", display_on_out, 1);
        send_byte(8'hAE, 0);
        chk("t4_off", display_on_out, 0);
        send_byte(8'h81, 0);
        send_byte(8'hAF, 0);
        chk("t4_arg", display_on_out, 0);

        send_win(8'h21, 8'h00, 8'h7F);
        send_win(8'h22, 8'h00, 8'h07);
        seen_addr.delete(); frames = 0; frame_at = 0;
        hp = 3;
        for (int i = 0; i < 1024; i++) send_byte(8'($urandom), 1);
        hp = 4;
        bad = 0;
        for (int i = 0; i < seen_addr.size(); i++) if (seen_addr[i] != i) bad++;
        chk("t3_count", seen_addr.size(), 1024);
        chk("t3_order_errors", bad, 0);
        chk("t3_frames", frames, 1);
        chk("t3_frame_at", frame_at, 1024);

        bad = byte_cnt;
        abort_bits(5);
        chk("t5_no_byte", byte_cnt, bad);
        chk("t5_err", cmd_error_out, 1);
        bad = seen_addr.size();
        send_byte(8'h21, 0);
        send_byte(8'h3C, 1);
        chk("t5_write", seen_addr.size(), bad + 1);
        chk("t5_err_sticky", cmd_error_out, 1);
        send_byte(8'hAF, 0);
        chk("t5_idle", display_on_out, 1);

        send_byte(8'h22, 0);
        pulse_reset();
        chk("t6_err_clear", cmd_error_out, 0);
        send_byte(8'hAF, 0);
        chk("t6_on", display_on_out, 1);
        send_byte(8'h5A, 1);
        chk("t6_addr", seen_addr[seen_addr.size()-1], 0);

        for (int n = 0; n < 110; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 50) send_byte(8'($urandom), 1);
            else if (r < 60) send_win(8'h21, 8'($urandom), 8'($urandom));
            else if (r < 68) send_win(8'h22, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
            else if (r < 75) send_byte($urandom_range(0, 1) != 0 ? 8'hAF : 8'hAE, 0);
            else if (r < 81) send_byte(one_tab[$urandom_range(0, 8)], 0);
            else if (r < 89) send_byte(8'($urandom), 0);
            else if (r < 94) cs_toggle();
            else if (r < 97) abort_bits($urandom_range(1, 7));
            else pulse_reset();
        end
        repeat (10) @(negedge clk);
        chk("end_bytes_drained", exp_bytes.size(), 0);
        chk("end_writes_drained", exp_wr.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
